// File: rtl/axis_port_pkt_fifo_if.sv
// AXI-Stream bundle carrying 32-bit data, byte keep and packet-end marker.
// The master drives payload and valid, and the slave drives ready.
interface axis_port_pkt_fifo_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_port_pkt_fifo.sv
// Per-port packet FIFO. It normally stores a whole packet before forwarding it.
// It falls back to cut-through when one packet alone fills the buffer.
module axis_port_pkt_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int PKT_CNT_W  = 7
) (
    input  logic                   glb_clk,
    input  logic                   glb_reset,
    axis_port_pkt_fifo_if.slave    s_axis,
    axis_port_pkt_fifo_if.master   m_axis,
    output logic [DEPTH_LOG2:0]    fill_level,
    output logic [PKT_CNT_W-1:0]   pkt_count,
    output logic                   oversize_pulse
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {
        MODE_STORE,
        MODE_CUT
    } mode_t;

    logic [36:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   fillLevel_q, fillLevel_d;
    logic [PKT_CNT_W-1:0]  pktCount_q, pktCount_d;
    mode_t                 mode_q, mode_d;
    logic                  oversizePulse_q, oversizePulse_d;

    logic        wrEn;
    logic        rdEn;
    logic        wrLast;
    logic        rdLast;
    logic [36:0] rdWord;

    // Ready and valid are derived from registered state only and are held low while in reset.
    assign rdWord        = mem[rdPtr_q];
    assign s_axis.tready = !glb_reset && (fillLevel_q != FULL_LEVEL);
    assign m_axis.tvalid = !glb_reset && (fillLevel_q != '0) &&
                           ((pktCount_q != '0) || (mode_q == MODE_CUT));
    assign m_axis.tlast  = rdWord[36];
    assign m_axis.tkeep  = rdWord[35:32];
    assign m_axis.tdata  = rdWord[31:0];

    assign wrEn   = s_axis.tvalid && s_axis.tready;
    assign rdEn   = m_axis.tvalid && m_axis.tready;
    assign wrLast = wrEn && s_axis.tlast;
    assign rdLast = rdEn && rdWord[36];

    assign fill_level     = fillLevel_q;
    assign pkt_count      = pktCount_q;
    assign oversize_pulse = oversizePulse_q;

    always_ff @(posedge glb_clk) begin
        if (wrEn) begin
            mem[wrPtr_q] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    always_comb begin
        wrPtr_d         = wrPtr_q;
        rdPtr_d         = rdPtr_q;
        fillLevel_d     = fillLevel_q;
        pktCount_d      = pktCount_q;
        mode_d          = mode_q;
        oversizePulse_d = 1'b0;

        if (wrEn) wrPtr_d = wrPtr_q + DEPTH_LOG2'(1);
        if (rdEn) rdPtr_d = rdPtr_q + DEPTH_LOG2'(1);

        case ({wrEn, rdEn})
            2'b10:   fillLevel_d = fillLevel_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   fillLevel_d = fillLevel_q - (DEPTH_LOG2 + 1)'(1);
            default: fillLevel_d = fillLevel_q;
        endcase

        case ({wrLast, rdLast})
            2'b10:   pktCount_d = pktCount_q + PKT_CNT_W'(1);
            2'b01:   pktCount_d = pktCount_q - PKT_CNT_W'(1);
            default: pktCount_d = pktCount_q;
        endcase

        // A full buffer with no complete packet can never make progress, so stream it out.
        case (mode_q)
            MODE_STORE: begin
                if ((fillLevel_q == FULL_LEVEL) && (pktCount_q == '0)) begin
                    mode_d          = MODE_CUT;
                    oversizePulse_d = 1'b1;
                end
            end
            MODE_CUT: begin
                if (rdLast) mode_d = MODE_STORE;
            end
            default: mode_d = MODE_STORE;
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (glb_reset) begin
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            fillLevel_q     <= '0;
            pktCount_q      <= '0;
            mode_q          <= MODE_STORE;
            oversizePulse_q <= 1'b0;
        end else begin
            wrPtr_q         <= wrPtr_d;
            rdPtr_q         <= rdPtr_d;
            fillLevel_q     <= fillLevel_d;
            pktCount_q      <= pktCount_d;
            mode_q          <= mode_d;
            oversizePulse_q <= oversizePulse_d;
        end
    end

endmodule
